// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA timing generator: scales 640x480 coordinates onto a small framebuffer,
// issues the read address, and emits RGB and sync on a common 3-cycle delay. Optional VGA_TEST_PATTERN_EN.
module vga_pixel_pipe #(
    parameter int SCALE_LOG2 = 2,
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int ADDR_W     = 16,
    parameter int COLOR_W    = 12
) (
    input  logic               ckVideo,
    input  logic               rstVideo,
    input  logic [9:0]         adrHor,
    input  logic [9:0]         adrVer,
    input  logic               flgActiveVideo,
    input  logic               HS,
    input  logic               VS,
    input  logic [ADDR_W-1:0]  fbBaseIn,
    input  logic [COLOR_W-1:0] bgColor,
    input  logic               selPattern,
    output logic [ADDR_W-1:0]  fbAddr,
    input  logic [COLOR_W-1:0] fbData,
    output logic [3:0]         vgaR,
    output logic [3:0]         vgaG,
    output logic [3:0]         vgaB,
    output logic               vgaHS,
    output logic               vgaVS,
    output logic [15:0]        frameCnt,
    output logic               flgFrameStart
);

    localparam logic [9:0]        FB_W_LIM = 10'(FB_W);
    localparam logic [9:0]        FB_H_LIM = 10'(FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);

    logic [9:0]         col;
    logic [9:0]         row;
    logic               inFb;
    logic [ADDR_W-1:0]  pixAddr;
    logic [ADDR_W-1:0]  baseShadow;
    logic               prevVS;

    logic               s1Active, s1InFb, s1Hs, s1Vs;
    logic               s2Active, s2InFb, s2Hs, s2Vs;
    logic [COLOR_W-1:0] pixelColor;

    assign col     = adrHor >> SCALE_LOG2;
    assign row     = adrVer >> SCALE_LOG2;
    assign inFb    = (col < FB_W_LIM) && (row < FB_H_LIM);
    // Sum is taken at ADDR_W bits so a high base wraps around the address space.
    assign pixAddr = baseShadow + ADDR_W'(row) * FB_W_A + ADDR_W'(col);

    // The base only moves on a VS falling edge, so a frame is always read from one buffer.
    always_ff @(posedge ckVideo) begin
        if (rstVideo) begin
            prevVS        <= 1'b0;
            baseShadow    <= '0;
            frameCnt      <= 16'd0;
            flgFrameStart <= 1'b0;
        end else begin
            prevVS        <= VS;
            flgFrameStart <= 1'b0;
            if (!VS && prevVS) begin
                baseShadow    <= fbBaseIn;
                frameCnt      <= frameCnt + 16'd1;
                flgFrameStart <= 1'b1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic s1PatSel, s1PatBit, s2PatSel, s2PatBit;

    always_ff @(posedge ckVideo) begin
        if (rstVideo) begin
            s1PatSel <= 1'b0;
            s1PatBit <= 1'b0;
            s2PatSel <= 1'b0;
            s2PatBit <= 1'b0;
        end else begin
            s1PatSel <= selPattern;
            s1PatBit <= adrHor[5] ^ adrVer[5];
            s2PatSel <= s1PatSel;
            s2PatBit <= s1PatBit;
        end
    end
`else
    logic unusedSel;
    assign unusedSel = selPattern;
`endif

    // Stage 1 issues the address; stage 2 waits out the synchronous read.
    always_ff @(posedge ckVideo) begin
        if (rstVideo) begin
            fbAddr   <= '0;
            s1Active <= 1'b0;
            s1InFb   <= 1'b0;
            s1Hs     <= 1'b1;
            s1Vs     <= 1'b1;
            s2Active <= 1'b0;
            s2InFb   <= 1'b0;
            s2Hs     <= 1'b1;
            s2Vs     <= 1'b1;
        end else begin
            fbAddr   <= inFb ? pixAddr : '0;
            s1Active <= flgActiveVideo;
            s1InFb   <= inFb;
            s1Hs     <= HS;
            s1Vs     <= VS;
            s2Active <= s1Active;
            s2InFb   <= s1InFb;
            s2Hs     <= s1Hs;
            s2Vs     <= s1Vs;
        end
    end

    always_comb begin
        pixelColor = '0;
        if (s2Active) begin
            pixelColor = s2InFb ? fbData : bgColor;
`ifdef VGA_TEST_PATTERN_EN
            if (s2PatSel) pixelColor = s2PatBit ? '1 : '0;
`endif
        end
    end

    // Stage 3: read data arrives this cycle and is registered alongside the delayed sync.
    always_ff @(posedge ckVideo) begin
        if (rstVideo) begin
            vgaR  <= 4'd0;
            vgaG  <= 4'd0;
            vgaB  <= 4'd0;
            vgaHS <= 1'b1;
            vgaVS <= 1'b1;
        end else begin
            vgaR  <= pixelColor[COLOR_W-1 -: 4];
            vgaG  <= pixelColor[7:4];
            vgaB  <= pixelColor[3:0];
            vgaHS <= s2Hs;
            vgaVS <= s2Vs;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe: default 160x120 instance plus a FB_W=100 instance to reach
// the background-colour path. Pattern checks are compiled only with VGA_TEST_PATTERN_EN.
module tb_vga_pixel_pipe;

    logic        ckVideo = 1'b0;
    logic        rstVideo;
    logic [9:0]  adrHor, adrVer;
    logic        flgActiveVideo, HS, VS;
    logic [15:0] fbBaseIn;
    logic [11:0] bgColor;
    logic        selPattern;

    logic [15:0] fbAddr, fbAddr2;
    logic [11:0] fbData, fbData2;
    logic [3:0]  vgaR, vgaG, vgaB, vgaR2, vgaG2, vgaB2;
    logic        vgaHS, vgaVS, vgaHS2, vgaVS2;
    logic [15:0] frameCnt, frameCnt2;
    logic        flgFrameStart, flgFrameStart2;
    logic [11:0] rgb1, rgb2;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [11:0] exp2_q[$];

    int   px[7]   = '{0, 4, 7, 636, 100, 8, 700};
    int   py[7]   = '{0, 0, 3, 476, 200, 4, 500};
    logic pa[7]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int   ea1[7]  = '{0, 1, 1, 19199, 8025, 162, 0};
    int   ea2[7]  = '{0, 1, 1, 0, 5025, 102, 0};
    logic out2[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 ckVideo = ~ckVideo;

    vga_pixel_pipe dut (
        .ckVideo(ckVideo), .rstVideo(rstVideo), .adrHor(adrHor), .adrVer(adrVer),
        .flgActiveVideo(flgActiveVideo), .HS(HS), .VS(VS), .fbBaseIn(fbBaseIn),
        .bgColor(bgColor), .selPattern(selPattern), .fbAddr(fbAddr), .fbData(fbData),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB), .vgaHS(vgaHS), .vgaVS(vgaVS),
        .frameCnt(frameCnt), .flgFrameStart(flgFrameStart)
    );

    vga_pixel_pipe #(.FB_W(100)) dut2 (
        .ckVideo(ckVideo), .rstVideo(rstVideo), .adrHor(adrHor), .adrVer(adrVer),
        .flgActiveVideo(flgActiveVideo), .HS(HS), .VS(VS), .fbBaseIn(fbBaseIn),
        .bgColor(bgColor), .selPattern(selPattern), .fbAddr(fbAddr2), .fbData(fbData2),
        .vgaR(vgaR2), .vgaG(vgaG2), .vgaB(vgaB2), .vgaHS(vgaHS2), .vgaVS(vgaVS2),
        .frameCnt(frameCnt2), .flgFrameStart(flgFrameStart2)
    );

    assign rgb1 = {vgaR, vgaG, vgaB};
    assign rgb2 = {vgaR2, vgaG2, vgaB2};

    // Framebuffer contents: a fixed marker at 162, an address-derived word elsewhere.
    function automatic logic [11:0] memWord(input logic [15:0] a);
        if (a == 16'd162) return 12'hA5C;
        return a[11:0] ^ 12'h3C6;
    endfunction

    always @(posedge ckVideo) begin
        fbData  <= memWord(fbAddr);
        fbData2 <= memWord(fbAddr2);
    end

    task automatic tick();
        @(posedge ckVideo);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic a);
        adrHor         = 10'(x);
        adrVer         = 10'(y);
        flgActiveVideo = a;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstVideo = 1'b1; HS = 1'b1; VS = 1'b0; selPattern = 1'b0;
        fbBaseIn = 16'd0; bgColor = 12'h3C9;
        drive(0, 0, 1'b0);

        // Reset, with VS low so no edge history exists when it releases.
        repeat (5) tick();
        check("rst_rgb",   32'(rgb1), 32'h0);
        check("rst_hs",    32'(vgaHS), 32'h1);
        check("rst_vs",    32'(vgaVS), 32'h1);
        check("rst_cnt",   32'(frameCnt), 32'h0);
        check("rst_pulse", 32'(flgFrameStart), 32'h0);
        check("rst_addr",  32'(fbAddr), 32'h0);
        rstVideo = 1'b0;
        tick();
        check("post_rst_pulse", 32'(flgFrameStart), 32'h0);
        tick();
        check("post_rst_cnt", 32'(frameCnt), 32'h0);
        VS = 1'b1;
        repeat (4) tick();
        check("vs_idle", 32'(vgaVS), 32'h1);
        check("no_pulse_on_rise", 32'(frameCnt), 32'h0);

        // Single pixel (8,4) with an HS edge: address, data and sync latency.
        drive(8, 4, 1'b1); HS = 1'b0;
        tick();
        check("addr_8_4", 32'(fbAddr), 32'd162);
        drive(0, 0, 1'b0); HS = 1'b1;
        tick();
        check("hs_lat2", 32'(vgaHS), 32'h1);
        tick();
        check("rgb_a5c", 32'(rgb1), 32'hA5C);
        check("hs_lat3", 32'(vgaHS), 32'h0);
        tick();
        check("hs_back", 32'(vgaHS), 32'h1);
        check("rgb_idle", 32'(rgb1), 32'h0);

        // Back-to-back pixels on both instances.
        for (int k = 0; k < 10; k++) begin
            if (k >= 1 && k <= 7) begin
                check("stream_addr1", 32'(fbAddr), 32'(ea1[k-1]));
                check("stream_addr2", 32'(fbAddr2), 32'(ea2[k-1]));
            end
            if (k >= 3) begin
                check("stream_rgb1", 32'(rgb1), 32'(exp_q.pop_front()));
                check("stream_rgb2", 32'(rgb2), 32'(exp2_q.pop_front()));
            end
            if (k < 7) begin
                drive(px[k], py[k], pa[k]);
                exp_q.push_back(pa[k] ? memWord(16'(ea1[k])) : 12'h000);
                exp2_q.push_back(!pa[k] ? 12'h000 : (out2[k] ? bgColor : memWord(16'(ea2[k]))));
            end else begin
                drive(0, 0, 1'b0);
            end
            tick();
        end

        // Base switch requested mid-frame, applied on the VS falling edge.
        fbBaseIn = 16'd19200;
        drive(0, 0, 1'b1);
        tick();
        check("base_hold", 32'(fbAddr), 32'h0);
        VS = 1'b0;
        tick();
        check("frame_pulse", 32'(flgFrameStart), 32'h1);
        check("frame_cnt1", 32'(frameCnt), 32'd1);
        check("addr_old_base", 32'(fbAddr), 32'h0);
        tick();
        check("pulse_1cyc", 32'(flgFrameStart), 32'h0);
        check("addr_new_base", 32'(fbAddr), 32'd19200);
        check("addr_new_base2", 32'(fbAddr2), 32'd19200);
        fbBaseIn = 16'd5;
        tick();
        check("base_ignored", 32'(fbAddr), 32'd19200);
        check("vgavs_low", 32'(vgaVS), 32'h0);
        VS = 1'b1;
        tick();
        fbBaseIn = 16'hFFFF; VS = 1'b0;
        drive(8, 0, 1'b1);
        tick();
        check("frame_cnt2", 32'(frameCnt), 32'd2);
        tick();
        check("addr_wrap", 32'(fbAddr), 32'd1);
        VS = 1'b1;
        tick();

        // Counter rollover from a preloaded 0xFFFF.
        force dut.frameCnt = 16'hFFFF;
        tick();
        release dut.frameCnt;
        tick();
        check("cnt_preload", 32'(frameCnt), 32'hFFFF);
        VS = 1'b0;
        tick();
        check("cnt_wrap", 32'(frameCnt), 32'h0);
        check("wrap_pulse", 32'(flgFrameStart), 32'h1);
        VS = 1'b1;
        tick();

`ifdef VGA_TEST_PATTERN_EN
        selPattern = 1'b1;
        exp_q.delete();
        exp_q.push_back(12'h000);
        exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h000);
        for (int k = 0; k < 6; k++) begin
            if (k >= 3) begin
                check("pattern_rgb2", 32'(rgb2), 32'(exp_q[k-3]));
                check("pattern_rgb1", 32'(rgb1), 32'(exp_q[k-3]));
            end
            case (k)
                0: drive(0, 0, 1'b1);
                1: drive(32, 0, 1'b1);
                2: drive(32, 32, 1'b1);
                default: drive(0, 0, 1'b0);
            endcase
            tick();
        end
        selPattern = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
